// File: rtl/out_display.sv
// ============================================================================
// out_display : output register with double-dabble decimal conversion and
//               a multiplexed four-digit seven-segment display driver.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module out_display #(
  parameter int SCAN_DIV   = 1024,
  parameter bit LEAD_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] bus,
  input  logic       oi,
  input  logic       signed_mode,
  output logic [7:0] out_reg,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_TC = PW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  logic [7:0]    out_reg_q, out_reg_d;
  logic          busy_q, busy_d;
  logic [3:0]    iter_q, iter_d;
  logic [19:0]   shift_q, shift_d;
  logic          neg_pend_q, neg_pend_d;
  logic [3:0]    hund_q, hund_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic          neg_q, neg_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;

  logic [7:0]    w_mag;
  logic          w_neg;

  // One double-dabble iteration: correct each BCD nibble, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int k = 0; k < 3; k++) begin
      if (t[8+4*k +: 4] >= 4'd5) t[8+4*k +: 4] = t[8+4*k +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // 0x80 negates to itself, which as an unsigned byte is exactly 128.
  assign w_neg = signed_mode & bus[7];
  assign w_mag = w_neg ? (~bus + 8'd1) : bus;

  always_comb begin
    out_reg_d  = out_reg_q;
    busy_d     = busy_q;
    iter_d     = iter_q;
    shift_d    = shift_q;
    neg_pend_d = neg_pend_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    units_d    = units_q;
    neg_d      = neg_q;
    pre_d      = pre_q + 1'b1;
    idx_d      = idx_q;

    if (busy_q) begin
      if (iter_q == 4'd8) begin
        hund_d  = shift_q[19:16];
        tens_d  = shift_q[15:12];
        units_d = shift_q[11:8];
        neg_d   = neg_pend_q;
        busy_d  = 1'b0;
      end else begin
        shift_d = dd_step(shift_q);
        iter_d  = iter_q + 4'd1;
      end
    end

    // A new load overrides whatever the converter was doing.
    if (oi) begin
      out_reg_d  = bus;
      shift_d    = {12'd0, w_mag};
      neg_pend_d = w_neg;
      iter_d     = 4'd0;
      busy_d     = 1'b1;
    end

    if (pre_q == PRE_TC) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      out_reg_q  <= 8'd0;
      busy_q     <= 1'b0;
      iter_q     <= 4'd0;
      shift_q    <= 20'd0;
      neg_pend_q <= 1'b0;
      hund_q     <= 4'd0;
      tens_q     <= 4'd0;
      units_q    <= 4'd0;
      neg_q      <= 1'b0;
      pre_q      <= '0;
      idx_q      <= 2'd0;
    end else begin
      out_reg_q  <= out_reg_d;
      busy_q     <= busy_d;
      iter_q     <= iter_d;
      shift_q    <= shift_d;
      neg_pend_q <= neg_pend_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      neg_q      <= neg_d;
      pre_q      <= pre_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    an  = 4'b0001 << idx_q;
    seg = SEG_BLANK;
    case (idx_q)
      2'd0: seg = seg_of(units_q);
      2'd1: seg = (LEAD_BLANK && hund_q == 4'd0 && tens_q == 4'd0) ? SEG_BLANK : seg_of(tens_q);
      2'd2: seg = (LEAD_BLANK && hund_q == 4'd0) ? SEG_BLANK : seg_of(hund_q);
      default: seg = neg_q ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  assign out_reg = out_reg_q;
  assign busy    = busy_q;

endmodule

`default_nettype wire

// File: doc/out_display.md
OUT_DISPLAY -- requirements
Module: out_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1024: clk cycles each digit is enabled (minimum 2).
REQ-002 SHALL have parameter LEAD_BLANK, default 1: 1 = suppress leading zeros, 0 = show all three decimal digits.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port bus  input  8: computer data bus, sampled when oi=1.
REQ-006 SHALL have port oi  input  1: output-register-in control bit, high for one or more cycles.
REQ-007 SHALL have port signed_mode  input  1: 1 = interpret value as two's complement, 0 = unsigned.
REQ-008 SHALL have port out_reg  output  8: latched output-register value.
REQ-009 SHALL have port seg  output  7: segments gfedcba, active-high.
REQ-010 SHALL have port an  output  4: one-hot digit enable, active-high; an[0]=units, an[3]=sign.
REQ-011 SHALL have port busy  output  1: high while a binary-to-BCD conversion is in progress.

Function
REQ-012 SHALL, on any edge with oi=1 and clr=1, load out_reg<=bus, load the magnitude into the converter, sample signed_mode and set busy=1 (edge E0).
REQ-013 SHALL compute magnitude as bus when signed_mode=0 or bus[7]=0, else the 9-bit two's-complement negation (0x80 -> 128); negative flag = signed_mode & bus[7].
REQ-014 SHALL convert with double-dabble: edges E1..E8 each perform add-3 on any BCD nibble >=5, then a left shift; exactly 8 iterations.
REQ-015 SHALL, at edge E9, copy hundreds/tens/units and the negative flag into display registers and clear busy; busy is high for exactly 9 cycles.
REQ-016 SHALL hold the display registers at the last completed result during a conversion.
REQ-017 SHALL, if oi=1 while busy, reload out_reg, abort and restart at E0 with the new value; the aborted value is never displayed.
REQ-018 SHALL leave signed_mode changes without effect until the next oi load.
REQ-019 SHALL run a prescaler 0..SCAN_DIV-1; at terminal count it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-020 SHALL drive an as the one-hot decode of the digit index; seg SHALL be combinational from the index and the display registers.
REQ-021 SHALL use seg encodings 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, minus=1000000, blank=0000000.
REQ-022 SHALL show minus on digit 3 when negative, else blank.
REQ-023 SHALL, with LEAD_BLANK=1, blank hundreds when 0 and tens when hundreds and tens are both 0; units are always shown.
REQ-024 SHALL keep the prescaler and scan running independently of conversions and oi.

Reset
REQ-025 SHALL, on an edge with clr=0, set out_reg=0, busy=0, converter idle, display registers=0, negative=0, prescaler=0, index=0, giving an=0001, seg=0111111.
REQ-026 SHALL give clr=0 priority over oi on the same edge and abort any conversion in progress.

Verification
REQ-027 SHALL cover reset: clr=0 one edge -> out_reg=00, busy=0, an=0001, seg=0111111.
REQ-028 SHALL cover unsigned max: signed_mode=0, bus=FF, oi 1 cycle -> busy 9 cycles; then digits 3..0 = blank,2,5,5.
REQ-029 SHALL cover signed extremes: signed_mode=1, bus=80 -> minus,1,2,8; bus=F9 -> minus,blank,blank,7; bus=7F -> blank,1,2,7.
REQ-030 SHALL cover oi-while-busy: bus=0C oi, then bus=2A oi 3 cycles later -> busy runs 9 cycles from the second load; display shows 4,2 and never 1,2.
REQ-031 SHALL cover reset mid-conversion: clr=0 at E4 after bus=C8 load -> next cycle all REQ-025 values; no 200 ever displayed.
REQ-032 SHALL cover scan with SCAN_DIV=4: an sequence 0001,0010,0100,1000,0001 changing every 4 cycles, seg matching each digit.
